// File: rtl/altr_hps_nandn_pkg.sv
// Shared constants and types for the N-input filtered NAND.
// Contents: parameter legality limits and the filter FSM state encoding.
package altr_hps_nandn_pkg;

    localparam int unsigned NANDN_MAX_IN     = 16;
    localparam int unsigned NANDN_MAX_PIPE   = 4;
    localparam int unsigned NANDN_MAX_FILT_W = 8;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } filt_state_t;

endpackage

// File: rtl/altr_hps_nandn_pipe.sv
// Parametrised 1-bit delay line with synchronous active-high reset.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, loads every stage with RST_VAL
//   din  - input bit
//   dout - din delayed by DEPTH cycles (DEPTH=0 is a plain wire)
module altr_hps_nandn_pipe #(
    parameter int unsigned DEPTH   = 1,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset are not needed for a zero-depth line.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else if (DEPTH == 1) begin : g_one
            logic stg;
            always_ff @(posedge clk) begin
                if (rst) stg <= RST_VAL;
                else     stg <= din;
            end
            assign dout = stg;
        end else begin : g_multi
            logic [DEPTH-1:0] stg;
            always_ff @(posedge clk) begin
                if (rst) stg <= {DEPTH{RST_VAL}};
                else     stg <= {stg[DEPTH-2:0], din};
            end
            assign dout = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/altr_hps_nandn_filt.sv
// N-input NAND with optional result pipeline and a programmable stability
// (deglitch) filter on the output.
// Ports:
//   clk        - sole clock
//   rst        - synchronous reset, active-high
//   en         - filter update enable (pipeline always shifts)
//   nand_in    - NAND operands
//   filt_thr   - stable cycles required before nand_out changes (0 acts as 1)
//   nand_raw   - unfiltered NAND after PIPE stages
//   nand_out   - filtered NAND result
//   chg_pulse  - one-cycle pulse coincident with a new nand_out value
//   sticky_clr - (ALTR_HPS_NANDN_FILT_STICKY_EN only) clears sticky_lo
//   sticky_lo  - (ALTR_HPS_NANDN_FILT_STICKY_EN only) latched qualified-low event
// Optional feature macro: ALTR_HPS_NANDN_FILT_STICKY_EN.
module altr_hps_nandn_filt
    import altr_hps_nandn_pkg::*;
#(
    parameter int unsigned NUM_IN  = 3,
    parameter int unsigned PIPE    = 1,
    parameter int unsigned FILT_W  = 4,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_IN-1:0] nand_in,
    input  logic [FILT_W-1:0] filt_thr,
`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
    input  logic              sticky_clr,
    output logic              sticky_lo,
`endif
    output logic              nand_raw,
    output logic              nand_out,
    output logic              chg_pulse
);

    // Elaboration-time parameter legality.
    generate
        if (NUM_IN < 2 || NUM_IN > NANDN_MAX_IN) begin : g_bad_num_in
            $error("altr_hps_nandn_filt: NUM_IN out of range 2..16");
        end
        if (PIPE > NANDN_MAX_PIPE) begin : g_bad_pipe
            $error("altr_hps_nandn_filt: PIPE out of range 0..4");
        end
        if (FILT_W < 1 || FILT_W > NANDN_MAX_FILT_W) begin : g_bad_filt_w
            $error("altr_hps_nandn_filt: FILT_W out of range 1..8");
        end
    endgenerate

    localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

    logic              raw_c;
    filt_state_t       state, state_nxt;
    logic [FILT_W-1:0] cnt, cnt_nxt;
    logic              out_nxt, pulse_nxt;
    logic [FILT_W-1:0] thr_eff;
    logic [FILT_W:0]   cnt_inc;
    logic              thr_hit;

    assign raw_c = ~&nand_in;

    altr_hps_nandn_pipe #(
        .DEPTH   (PIPE),
        .RST_VAL (RST_VAL)
    ) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_c),
        .dout (nand_raw)
    );

    // Threshold is compared live; the extra bit keeps cnt+1 from wrapping.
    assign thr_eff = (filt_thr == '0) ? CNT_ONE : filt_thr;
    assign cnt_inc = {1'b0, cnt} + (FILT_W + 1)'(1);
    assign thr_hit = (cnt_inc >= {1'b0, thr_eff});

    // Filter state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STABLE;
            cnt       <= '0;
            nand_out  <= RST_VAL;
            chg_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            nand_out  <= out_nxt;
            chg_pulse <= pulse_nxt;
        end
    end

    // Next-state: qualify a mismatch for thr_eff enabled cycles before flipping.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = nand_out;
        pulse_nxt = 1'b0;
        case (state)
            ST_STABLE: begin
                cnt_nxt = '0;
                if (en && (nand_raw != nand_out)) begin
                    // cnt is 0 here, so thr_hit means a threshold of one.
                    if (thr_hit) begin
                        out_nxt   = nand_raw;
                        pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = ST_QUAL;
                    end
                end
            end
            ST_QUAL: begin
                if (en) begin
                    if (nand_raw == nand_out) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_STABLE;
                    end else if (thr_hit) begin
                        out_nxt   = nand_raw;
                        pulse_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_STABLE;
                    end else if (cnt != '1) begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_STABLE;
            end
        endcase
    end

`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
    // Latch a qualified falling output; a simultaneous set beats the clear.
    always_ff @(posedge clk) begin
        if (rst)                       sticky_lo <= 1'b0;
        else if (pulse_nxt && !out_nxt) sticky_lo <= 1'b1;
        else if (sticky_clr)           sticky_lo <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_altr_hps_nandn_filt.sv
// Directed bench for altr_hps_nandn_filt: a run-length filter model checked
// every cycle, plus literal latency/pulse expectations per scenario.
module tb_altr_hps_nandn_filt;

    localparam int unsigned NUM_IN = 3;
    localparam int unsigned PIPE   = 1;
    localparam int unsigned FILT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NUM_IN-1:0] nand_in;
    logic [FILT_W-1:0] filt_thr;
    logic              nand_raw, nand_out, chg_pulse;

    logic [15:0]       in2;
    logic [3:0]        thr2;
    logic              en2;
    logic              raw2, out2, pulse2;

`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
    logic sticky_clr, sticky_lo;
    logic sticky_clr2, sticky_lo2;
    bit   m_sticky;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    altr_hps_nandn_filt #(.NUM_IN(NUM_IN), .PIPE(PIPE), .FILT_W(FILT_W), .RST_VAL(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .nand_in(nand_in), .filt_thr(filt_thr),
`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_lo(sticky_lo),
`endif
        .nand_raw(nand_raw), .nand_out(nand_out), .chg_pulse(chg_pulse)
    );

    altr_hps_nandn_filt #(.NUM_IN(16), .PIPE(0), .FILT_W(4), .RST_VAL(1'b1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .nand_in(in2), .filt_thr(thr2),
`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
        .sticky_clr(sticky_clr2), .sticky_lo(sticky_lo2),
`endif
        .nand_raw(raw2), .nand_out(out2), .chg_pulse(pulse2)
    );

    // ---------------- behavioural model ----------------
    bit rq[$];         // raw NAND history, newest first
    bit m_out;
    bit m_pulse;
    int m_run;         // consecutive enabled mismatch cycles
    bit started = 1'b0;

    function automatic bit model_raw();
        if (PIPE == 0) return ~&nand_in;
        return rq[PIPE-1];
    endfunction

    always @(posedge clk) begin
        bit rb;
        int te;
        rb = model_raw();
        te = (filt_thr == 0) ? 1 : int'(filt_thr);
        started = 1'b1;
        if (rst) begin
            rq.delete();
            for (int i = 0; i < int'(PIPE); i++) rq.push_back(1'b1);
            m_out   = 1'b1;
            m_pulse = 1'b0;
            m_run   = 0;
`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
            m_sticky = 1'b0;
`endif
        end else begin
            if (PIPE > 0) begin
                rq.push_front(~&nand_in);
                void'(rq.pop_back());
            end
            m_pulse = 1'b0;
            if (en) begin
                if (rb != m_out) begin
                    m_run++;
                    if (m_run >= te) begin
                        m_out   = rb;
                        m_pulse = 1'b1;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
            if (m_pulse && !m_out) m_sticky = 1'b1;
            else if (sticky_clr)   m_sticky = 1'b0;
`endif
        end
    end

    task automatic cmp(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            cmp("nand_raw", nand_raw, model_raw());
            cmp("nand_out", nand_out, m_out);
            cmp("chg_pulse", chg_pulse, m_pulse);
`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
            cmp("sticky_lo", sticky_lo, m_sticky);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply();
        @(posedge clk);
        #1;
    endtask

    // Step until nand_out == exp (bounded); report cycles taken and pulses seen.
    task automatic wait_out(input logic exp, input int bound, output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (n < bound) begin
            apply();
            n++;
            if (chg_pulse) pulses++;
            if (nand_out == exp) break;
        end
    endtask

    int n, p, k;

    initial begin
        for (int i = 0; i < int'(PIPE); i++) rq.push_back(1'b1);
        rst = 1'b1; en = 1'b1; nand_in = 3'b111; filt_thr = 4'd4;
        in2 = 16'h0000; thr2 = 4'd0; en2 = 1'b1;
`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
        sticky_clr = 1'b0; sticky_clr2 = 1'b0;
`endif
        apply();
        apply();
        cmp("rst_out", nand_out, 1'b1);
        cmp("rst_raw", nand_raw, 1'b1);
        cmp("rst_pulse", chg_pulse, 1'b0);

        // Idle with raw matching the reset output value.
        rst = 1'b0; nand_in = 3'b011;
        repeat (8) apply();
        cmp("idle_out", nand_out, 1'b1);

        // Basic flip: 1 pipe cycle + 4 qualification cycles.
        nand_in = 3'b111;
        wait_out(1'b0, 30, n, p);
        cmp_int("basic_latency", n, 5);
        cmp_int("basic_pulses", p, 1);
        apply();
        cmp("basic_pulse_end", chg_pulse, 1'b0);

        nand_in = 3'b011;
        wait_out(1'b1, 30, n, p);
        cmp_int("rise_latency", n, 5);

        // Glitch shorter than the threshold is rejected.
        p = 0;
        nand_in = 3'b111;
        repeat (2) begin apply(); if (chg_pulse) p++; end
        nand_in = 3'b110;
        repeat (10) begin apply(); if (chg_pulse) p++; end
        cmp("glitch_out", nand_out, 1'b1);
        cmp_int("glitch_pulses", p, 0);

        // Enable stall mid-qualification, threshold 3.
        filt_thr = 4'd3;
        nand_in = 3'b111;
        repeat (2) apply();
        en = 1'b0;
        repeat (5) apply();
        cmp("stall_hold", nand_out, 1'b1);
        en = 1'b1;
        wait_out(1'b0, 30, n, p);
        cmp_int("stall_resume", n, 2);

        // Reset in the middle of qualification.
        filt_thr = 4'd4;
        nand_in = 3'b011;
        repeat (3) apply();
        rst = 1'b1;
        apply();
        rst = 1'b0;
        p = 0;
        repeat (6) begin apply(); if (chg_pulse) p++; end
        cmp_int("midrst_pulses", p, 0);

        // Threshold 0 behaves as 1.
        filt_thr = 4'd0;
        nand_in = 3'b111;
        wait_out(1'b0, 30, n, p);
        cmp_int("thr0_latency", n, 2);

        // Maximum threshold: flip after exactly 15 mismatch cycles.
        filt_thr = 4'd15;
        nand_in = 3'b011;
        k = 0; p = 0;
        for (int i = 1; i <= 20; i++) begin
            apply();
            if (chg_pulse) p++;
            if (nand_out && k == 0) k = i;
        end
        cmp_int("thr15_latency", k, 16);
        cmp_int("thr15_pulses", p, 1);

        // Lowering the threshold below cnt+1 flips on the next edge.
        nand_in = 3'b111;
        repeat (6) apply();
        cmp("lower_before", nand_out, 1'b1);
        filt_thr = 4'd2;
        apply();
        cmp("lower_flip", nand_out, 1'b0);
        cmp("lower_pulse", chg_pulse, 1'b1);

        // Wide, unpipelined instance with threshold 0.
        cmp("w16_raw_idle", raw2, 1'b1);
        cmp("w16_out_idle", out2, 1'b1);
        in2 = 16'hFFFF;
        #1;
        cmp("w16_raw_comb", raw2, 1'b0);
        apply();
        cmp("w16_out", out2, 1'b0);
        cmp("w16_pulse", pulse2, 1'b1);
        apply();
        cmp("w16_pulse_end", pulse2, 1'b0);

`ifdef ALTR_HPS_NANDN_FILT_STICKY_EN
        cmp("sticky_set", sticky_lo, 1'b1);
        nand_in = 3'b011;
        wait_out(1'b1, 30, n, p);
        cmp("sticky_kept", sticky_lo, 1'b1);
        sticky_clr = 1'b1;
        apply();
        sticky_clr = 1'b0;
        cmp("sticky_clr", sticky_lo, 1'b0);
        filt_thr = 4'd1;
        nand_in = 3'b111;
        apply();
        sticky_clr = 1'b1;
        apply();
        sticky_clr = 1'b0;
        cmp("sticky_set_wins_out", nand_out, 1'b0);
        cmp("sticky_set_wins", sticky_lo, 1'b1);
`endif

        repeat (3) apply();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/altr_hps_nandn_filt.md
Name: altr_hps_nandn_filt

Overview:
- Parametrised N-input NAND with an optional pipeline on the reduced result and a programmable stability (deglitch) filter on the output.
- Next-generation replacement for the fixed-width hard NAND macros.
- Used on HPS status/ready aggregation paths where a qualified, glitch-free NAND of several sideband conditions is needed in a single clock domain.

Parameters:
- NUM_IN, 3, number of NAND inputs; legal 2..16.
- PIPE, 1, register stages between the NAND reduction and the filter; legal 0..4; 0 means combinational into the filter.
- FILT_W, 4, width of the filter counter and of the threshold input; legal 1..8.
- RST_VAL, 1'b1, reset value of the pipeline stages and of nand_out.

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  filter update enable; when low, filter state and output hold.
- nand_in  input  NUM_IN  NAND operands.
- filt_thr  input  FILT_W  required stable cycles before nand_out changes; 0 is treated as 1.
- nand_raw  output  1  unfiltered NAND after PIPE stages.
- nand_out  output  1  filtered NAND result.
- chg_pulse  output  1  one-cycle pulse in the cycle nand_out takes its new value.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high; all state updates only on the rising edge of clk.
- Reduction: raw = ~&nand_in.
- Pipeline:
  - PIPE stages shift every cycle regardless of en.
  - nand_raw is the last stage, or raw when PIPE=0.
  - Latency from nand_in to nand_raw is PIPE cycles.
- Reset, sampled at a clk edge while rst=1:
  - pipeline stages = RST_VAL, nand_raw = RST_VAL.
  - nand_out = RST_VAL, chg_pulse = 0.
  - cnt = 0, FSM = ST_STABLE.
  - Reset mid-qualification discards the count; no chg_pulse is generated.
- FSM, two states; thr_eff = (filt_thr==0) ? 1 : filt_thr:
  - ST_STABLE, nand_raw == nand_out: cnt = 0.
    - If en=1 and nand_raw != nand_out: cnt <= 1, go to ST_QUAL.
    - If thr_eff==1, instead flip nand_out in that same edge, pulse chg_pulse, and stay in ST_STABLE.
  - ST_QUAL:
    - en=0: hold cnt and state.
    - nand_raw == nand_out (glitch ended): cnt <= 0, go to ST_STABLE, no output change.
    - nand_raw != nand_out and cnt+1 >= thr_eff: nand_out <= nand_raw, chg_pulse <= 1, cnt <= 0, go to ST_STABLE.
    - Otherwise cnt <= cnt+1, saturating at 2^FILT_W-1.
- Net latency from a stable change at nand_raw to nand_out: exactly thr_eff cycles with en held high.
- chg_pulse is registered, high for exactly one cycle, and coincident with the new nand_out value.
- filt_thr may change at any time and is compared live. Lowering it below the current cnt+1 causes a flip on the next edge.
- A nand_raw toggle on the same edge the threshold is reached: compare against the sampled nand_raw only; no special case.

Optional Feature:
- Macro: ALTR_HPS_NANDN_FILT_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1) and output sticky_lo (1).
  - sticky_lo sets on any cycle where chg_pulse=1 and nand_out becomes 0 (all inputs high, qualified).
  - sticky_lo clears on sticky_clr=1.
  - Set and clear in the same cycle: set wins.
  - Reset value 0.
- Undefined: sticky_clr and sticky_lo ports absent; no sticky flop is present.

Decomposition:
- Package altr_hps_nandn_pkg:
  - Constants NANDN_MAX_IN=16, NANDN_MAX_PIPE=4, NANDN_MAX_FILT_W=8.
  - Enum filt_state_t {ST_STABLE, ST_QUAL}.
- One sub-module: altr_hps_nandn_pipe, a parametrised 1-bit delay line (DEPTH, RST_VAL, sync active-high reset). DEPTH=0 is a wire.
- Top instantiates altr_hps_nandn_pipe and contains the FSM and counter.
- Parameter legality is checked at elaboration (error on out-of-range values).

Test Plan:
- Reset: rst=1 for 2 cycles with nand_in=3'b111 → nand_out=1, nand_raw=1, chg_pulse=0; all three hold these values for PIPE cycles after release.
- Basic flip, NUM_IN=3, PIPE=1, filt_thr=4, en=1: nand_in goes 3'b011→3'b111 and holds.
  - nand_raw falls 1 cycle later.
  - nand_out falls 4 cycles after nand_raw.
  - chg_pulse is high for exactly that one cycle.
- Glitch rejection, filt_thr=4: nand_in=3'b111 for 2 cycles, then 3'b110 → nand_out stays 1, no chg_pulse, FSM returns to ST_STABLE with cnt=0.
- Enable stall, filt_thr=3: en=0 for 5 cycles in the middle of qualification → cnt frozen; nand_out falls after 3 total en=1 cycles of mismatch.
- Edge parameters:
  - filt_thr=0, PIPE=0, NUM_IN=16: nand_in=16'hFFFF → nand_out=0 one edge later.
  - filt_thr=15, FILT_W=4: mismatch held for 20 cycles → flip at cycle 15, counter never wraps.
- Sticky (macro defined):
  - nand_out qualifies low → sticky_lo=1 and stays 1 after inputs return low.
  - sticky_clr pulsed in the same cycle as a new falling chg_pulse → sticky_lo remains 1.
